// File: rtl/controle_multiciclo_if.sv
// Control bus between the multicycle controller (master) and the datapath it
// steers (slave). Carries the IR opcode, the memory handshake and every control line.
interface controle_multiciclo_if #(
  parameter int OPCODE_W = 6,
  parameter int ESTADO_W = 3
);
  logic [OPCODE_W-1:0] opcode;
  logic                mem_pronto;
  logic [1:0]          ula_opcode;
  logic [1:0]          reg_dest;
  logic [1:0]          mem_to_reg;
  logic                ula_src;
  logic                mem_escrita;
  logic                mem_leitura;
  logic                reg_escrita;
  logic                branch;
  logic                jump;
  logic                sign_zero;
  logic                pc_escrita;
  logic                ir_escrita;
  logic                instr_fim;
  logic                ilegal;
  logic [ESTADO_W-1:0] estado;

  modport master (
    input  opcode, mem_pronto,
    output ula_opcode, reg_dest, mem_to_reg, ula_src, mem_escrita, mem_leitura,
           reg_escrita, branch, jump, sign_zero, pc_escrita, ir_escrita,
           instr_fim, ilegal, estado
  );

  modport slave (
    output opcode, mem_pronto,
    input  ula_opcode, reg_dest, mem_to_reg, ula_src, mem_escrita, mem_leitura,
           reg_escrita, branch, jump, sign_zero, pc_escrita, ir_escrita,
           instr_fim, ilegal, estado
  );
endinterface

// File: rtl/controle_multiciclo.sv
// Multicycle MIPS-like control FSM (fetch/decode/exec/mem/writeback).
// Define CONTROLE_ILEGAL_EN to trap opcodes with nonzero upper bits in a sticky ILEGAL state.
module controle_multiciclo #(
  parameter int OPCODE_W = 6,
  parameter int ESTADO_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  controle_multiciclo_if.master bus
);

  typedef enum logic [2:0] {
    BUSCA  = 3'd0,
    DECOD  = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    ESCR   = 3'd4,
    ILEGAL = 3'd5
  } estado_t;

  typedef enum logic [2:0] {
    OP_R    = 3'd0,
    OP_ADDI = 3'd1,
    OP_ORI  = 3'd2,
    OP_LW   = 3'd3,
    OP_SW   = 3'd4,
    OP_BEQ  = 3'd5,
    OP_J    = 3'd6,
    OP_JAL  = 3'd7
  } op_t;

  estado_t state, next;
  op_t     op_reg;
  logic    upper_nz;

  logic [1:0] ula_opcode_c, reg_dest_c, mem_to_reg_c;
  logic       ula_src_c, mem_escrita_c, mem_leitura_c, reg_escrita_c;
  logic       branch_c, jump_c, sign_zero_c, pc_escrita_c, ir_escrita_c;
  logic       instr_fim_c, ilegal_c;

  generate
    if (OPCODE_W > 3) begin : g_upper
      assign upper_nz = |bus.opcode[OPCODE_W-1:3];
    end else begin : g_no_upper
      assign upper_nz = 1'b0;
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= BUSCA;
      op_reg <= OP_R;
    end else begin
      state <= next;
      if (state == DECOD) op_reg <= op_t'(bus.opcode[2:0]);
    end
  end

  always_comb begin
    next          = state;
    ula_opcode_c  = 2'b00;
    reg_dest_c    = 2'b00;
    mem_to_reg_c  = 2'b00;
    ula_src_c     = 1'b0;
    mem_escrita_c = 1'b0;
    mem_leitura_c = 1'b0;
    reg_escrita_c = 1'b0;
    branch_c      = 1'b0;
    jump_c        = 1'b0;
    sign_zero_c   = 1'b0;
    pc_escrita_c  = 1'b0;
    ir_escrita_c  = 1'b0;
    instr_fim_c   = 1'b0;
    ilegal_c      = 1'b0;

    case (state)
      BUSCA: begin
        mem_leitura_c = 1'b1;
        pc_escrita_c  = bus.mem_pronto;
        ir_escrita_c  = bus.mem_pronto;
        if (bus.mem_pronto) next = DECOD;
      end

      DECOD: begin
        next = EXEC;
`ifdef CONTROLE_ILEGAL_EN
        if (upper_nz) next = ILEGAL;
`endif
      end

      EXEC: begin
        case (op_reg)
          OP_R: begin
            ula_opcode_c = 2'b10;
            next         = ESCR;
          end
          OP_ADDI: begin
            ula_src_c   = 1'b1;
            sign_zero_c = 1'b1;
            next        = ESCR;
          end
          OP_ORI: begin
            ula_src_c    = 1'b1;
            ula_opcode_c = 2'b11;
            next         = ESCR;
          end
          OP_LW, OP_SW: begin
            ula_src_c   = 1'b1;
            sign_zero_c = 1'b1;
            next        = MEM;
          end
          OP_BEQ: begin
            ula_opcode_c = 2'b01;
            branch_c     = 1'b1;
            instr_fim_c  = 1'b1;
            next         = BUSCA;
          end
          OP_J: begin
            jump_c      = 1'b1;
            instr_fim_c = 1'b1;
            next        = BUSCA;
          end
          OP_JAL: begin
            jump_c = 1'b1;
            next   = ESCR;
          end
          default: next = BUSCA;
        endcase
      end

      MEM: begin
        // Access strobe is held for the whole wait; only the exit depends on mem_pronto.
        case (op_reg)
          OP_LW: begin
            mem_leitura_c = 1'b1;
            if (bus.mem_pronto) next = ESCR;
          end
          OP_SW: begin
            mem_escrita_c = 1'b1;
            if (bus.mem_pronto) begin
              instr_fim_c = 1'b1;
              next        = BUSCA;
            end
          end
          default: next = BUSCA;
        endcase
      end

      ESCR: begin
        reg_escrita_c = 1'b1;
        instr_fim_c   = 1'b1;
        next          = BUSCA;
        case (op_reg)
          OP_R:   reg_dest_c = 2'b01;
          OP_LW:  mem_to_reg_c = 2'b01;
          OP_JAL: begin
            reg_dest_c   = 2'b10;
            mem_to_reg_c = 2'b10;
          end
          default: ;
        endcase
      end

      ILEGAL: begin
        ilegal_c = 1'b1;
        next     = ILEGAL;
      end

      default: next = BUSCA;
    endcase
  end

  // Reset masks every control combinationally so an abandoned instruction never writes.
  assign bus.ula_opcode  = reset ? '0 : ula_opcode_c;
  assign bus.reg_dest    = reset ? '0 : reg_dest_c;
  assign bus.mem_to_reg  = reset ? '0 : mem_to_reg_c;
  assign bus.ula_src     = ula_src_c     & ~reset;
  assign bus.mem_escrita = mem_escrita_c & ~reset;
  assign bus.mem_leitura = mem_leitura_c & ~reset;
  assign bus.reg_escrita = reg_escrita_c & ~reset;
  assign bus.branch      = branch_c      & ~reset;
  assign bus.jump        = jump_c        & ~reset;
  assign bus.sign_zero   = sign_zero_c   & ~reset;
  assign bus.pc_escrita  = pc_escrita_c  & ~reset;
  assign bus.ir_escrita  = ir_escrita_c  & ~reset;
  assign bus.instr_fim   = instr_fim_c   & ~reset;
  assign bus.estado      = ESTADO_W'(state);

`ifdef CONTROLE_ILEGAL_EN
  assign bus.ilegal = ilegal_c & ~reset;
`else
  logic unused_ilegal;
  assign unused_ilegal = ilegal_c ^ upper_nz;
  assign bus.ilegal    = 1'b0;
`endif

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed self-checking bench for controle_multiciclo: walks every opcode class,
// memory stalls, opcode changes outside DECOD, reset abort and the illegal-opcode option.
module tb_controle_multiciclo;

  localparam int OPCODE_W = 6;
  localparam int ESTADO_W = 3;

  localparam logic [31:0] ILG = 32'h1 << 0;
  localparam logic [31:0] FIM = 32'h1 << 1;
  localparam logic [31:0] IRW = 32'h1 << 2;
  localparam logic [31:0] PCW = 32'h1 << 3;
  localparam logic [31:0] SZ  = 32'h1 << 4;
  localparam logic [31:0] JMP = 32'h1 << 5;
  localparam logic [31:0] BR  = 32'h1 << 6;
  localparam logic [31:0] RW  = 32'h1 << 7;
  localparam logic [31:0] MR  = 32'h1 << 8;
  localparam logic [31:0] MW  = 32'h1 << 9;
  localparam logic [31:0] SRC = 32'h1 << 10;
  localparam logic [31:0] FETCH = MR | PCW | IRW;

  function automatic logic [31:0] m2r(input int v); return 32'(v) << 11; endfunction
  function automatic logic [31:0] rd(input int v);  return 32'(v) << 13; endfunction
  function automatic logic [31:0] ula(input int v); return 32'(v) << 15; endfunction

  logic clock = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  controle_multiciclo_if #(.OPCODE_W(OPCODE_W), .ESTADO_W(ESTADO_W)) bus ();

  controle_multiciclo #(.OPCODE_W(OPCODE_W), .ESTADO_W(ESTADO_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [31:0] ctl;
  assign ctl = {15'b0, bus.ula_opcode, bus.reg_dest, bus.mem_to_reg, bus.ula_src,
                bus.mem_escrita, bus.mem_leitura, bus.reg_escrita, bus.branch, bus.jump,
                bus.sign_zero, bus.pc_escrita, bus.ir_escrita, bus.instr_fim, bus.ilegal};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Check state code and control vector in the current cycle, then advance one clock.
  task automatic step(input string tag, input int est, input logic [31:0] exp_ctl);
    #1;
    check({tag, ".estado"}, 32'(bus.estado), 32'(est));
    check({tag, ".ctl"}, ctl, exp_ctl);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.mem_pronto = 1'b1;
    bus.opcode = 6'b000000;

    @(posedge clock); #1;
    check("rst0.estado", 32'(bus.estado), 32'd0);
    check("rst0.ctl", ctl, 32'h0);
    @(posedge clock); #1;
    check("rst1.ctl", ctl, 32'h0);
    reset = 1'b0;

    // R-type
    step("r.busca", 0, FETCH);
    step("r.decod", 1, 32'h0);
    step("r.exec",  2, ula(2));
    step("r.escr",  4, RW | FIM | rd(1));

    // LW with two memory wait cycles; opcode changed after DECOD must be ignored
    bus.opcode = 6'b000011;
    step("lw.busca", 0, FETCH);
    step("lw.decod", 1, 32'h0);
    bus.opcode = 6'b000110;
    step("lw.exec", 2, SRC | SZ | ula(0));
    bus.mem_pronto = 1'b0;
    step("lw.mem0", 3, MR);
    step("lw.mem1", 3, MR);
    bus.mem_pronto = 1'b1;
    step("lw.mem2", 3, MR);
    step("lw.escr", 4, RW | FIM | m2r(1));

    // JAL
    bus.opcode = 6'b000111;
    step("jal.busca", 0, FETCH);
    step("jal.decod", 1, 32'h0);
    step("jal.exec",  2, JMP);
    step("jal.escr",  4, RW | FIM | rd(2) | m2r(2));

    // BEQ (3 cycles)
    bus.opcode = 6'b000101;
    step("beq.busca", 0, FETCH);
    step("beq.decod", 1, 32'h0);
    step("beq.exec",  2, ula(1) | BR | FIM);

    // J (3 cycles)
    bus.opcode = 6'b000110;
    step("j.busca", 0, FETCH);
    step("j.decod", 1, 32'h0);
    step("j.exec",  2, JMP | FIM);

    // ORI
    bus.opcode = 6'b000010;
    step("ori.busca", 0, FETCH);
    step("ori.decod", 1, 32'h0);
    step("ori.exec",  2, SRC | ula(3));
    step("ori.escr",  4, RW | FIM);

    // ADDI
    bus.opcode = 6'b000001;
    step("addi.busca", 0, FETCH);
    step("addi.decod", 1, 32'h0);
    step("addi.exec",  2, SRC | SZ);
    step("addi.escr",  4, RW | FIM);

    // SW with one fetch wait cycle
    bus.opcode = 6'b000100;
    bus.mem_pronto = 1'b0;
    step("sw.busca_wait", 0, MR);
    bus.mem_pronto = 1'b1;
    step("sw.busca", 0, FETCH);
    step("sw.decod", 1, 32'h0);
    step("sw.exec",  2, SRC | SZ);
    step("sw.mem",   3, MW | FIM);

    // Opcode with nonzero upper bits
    bus.opcode = 6'b001000;
    step("il.busca", 0, FETCH);
    step("il.decod", 1, 32'h0);
`ifdef CONTROLE_ILEGAL_EN
    bus.opcode = 6'b000000;
    for (int i = 0; i < 10; i++) step("il.hold", 5, ILG);
    reset = 1'b1;
    #1;
    check("il.rst_comb", ctl, 32'h0);
    @(posedge clock); #1;
    check("il.rst_estado", 32'(bus.estado), 32'd0);
    reset = 1'b0;
`else
    step("il.exec", 2, ula(2));
    step("il.escr", 4, RW | FIM | rd(1));
`endif

    // Reset during SW memory wait
    bus.opcode = 6'b000100;
    step("swr.busca", 0, FETCH);
    step("swr.decod", 1, 32'h0);
    step("swr.exec",  2, SRC | SZ);
    bus.mem_pronto = 1'b0;
    #1;
    check("swr.mem_wait", ctl, MW);
    reset = 1'b1;
    #1;
    check("swr.rst_comb", ctl, 32'h0);
    check("swr.rst_estado_hold", 32'(bus.estado), 32'd3);
    @(posedge clock); #1;
    check("swr.rst_estado", 32'(bus.estado), 32'd0);
    check("swr.rst_ctl", ctl, 32'h0);
    reset = 1'b0;
    bus.mem_pronto = 1'b1;
    step("post.busca", 0, FETCH);
    step("post.decod", 1, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
